mem_access: RTL
===============

// Module: mem_access
// PURPOSE
//   Memory stage directly downstream of execute: consumes the ALU result (address) and forwarded
//   rs2 operand (store data), runs one data-memory bus transaction per load/store, aligns and
//   extends load data, and presents a registered result to writeback. Holds the PC via o_stall.
// PARAMETERS
//   TIMEOUT   255   max cycles waiting for i_mem_ack before abort (0 = wait forever)
// PORTS
//   i_clk        in   1   clock, all state on rising edge
//   i_rst        in   1   asynchronous, active-high reset
//   i_valid      in   1   instruction from execute valid this cycle
//   i_memRead    in   1   load
//   i_memWrite   in   1   store (i_memRead & i_memWrite never both set)
//   i_size       in   2   00 byte, 01 half, 10 word (11 treated as word)
//   i_unsigned   in   1   zero-extend loads (lbu/lhu)
//   i_ALUres     in   32  address for ld/st, result for non-memory ops
//   i_op2        in   32  store data
//   o_stall      out  1   freeze PC/execute inputs
//   o_mem_req    out  1   bus request, held until ack
//   o_mem_we     out  1   write strobe, valid with o_mem_req
//   o_mem_addr   out  32  word-aligned address ({addr[31:2],2'b00})
//   o_mem_be     out  4   byte enables
//   o_mem_wdata  out  32  lane-replicated store data
//   i_mem_ack    in   1   transaction complete; i_mem_rdata valid same cycle
//   i_mem_rdata  in   32  read word
//   o_wb_valid   out  1   one-cycle pulse: o_wb_data valid
//   o_wb_data    out  32  load data or passed-through ALU result
//   o_misalign   out  1   one-cycle pulse: misaligned access dropped
//   o_bus_err    out  1   one-cycle pulse: timeout abort
// BEHAVIOUR
//   Reset: state IDLE; timer 0; all outputs 0.
//   FSM IDLE -> BUSY -> RESP -> IDLE.
//   IDLE, i_valid, no mem op: latch i_ALUres; o_wb_valid=1 next cycle (latency 1); no stall.
//   IDLE, i_valid, mem op, aligned: o_stall=1 combinationally; latch addr/data/size/we; -> BUSY.
//   Misaligned = half with addr[0]=1, or word with addr[1:0]!=0: no bus cycle, no wb_valid,
//     o_misalign=1 next cycle, stay IDLE, no stall.
//   BUSY: o_mem_req=1, o_stall=1, bus outputs stable; timer increments each cycle.
//     i_mem_ack: capture aligned/extended rdata (loads) -> RESP. Stores: o_wb_data=0.
//     timer reaches TIMEOUT without ack: drop req, o_bus_err=1 next cycle, -> IDLE, no wb_valid.
//     ack and timeout in same cycle: ack wins.
//   RESP: o_wb_valid=1 one cycle, o_stall=0 (PC advances this cycle) -> IDLE. i_valid in RESP is
//     not accepted; execute holds it until IDLE (stall low here means new instruction arrives next).
//   Minimum mem-op latency: accept T, req T+1, ack T+1 -> o_wb_valid T+2.
//   Byte enables: byte 4'b0001<<addr[1:0]; half addr[1]?1100:0011; word 1111.
//   Store data: byte {4{op2[7:0]}}, half {2{op2[15:0]}}, word op2.
//   Load: select lane by addr[1:0] (big lane = higher address bits [31:24] for addr 3, little-endian);
//     sign-extend unless i_unsigned; word ignores i_unsigned.
//   Reset mid-transaction: req drops asynchronously; no wb_valid/err pulse after release.
// STRUCTURE
//   Shared package mem_pkg: SIZE_BYTE/HALF/WORD constants, FSM state encodings, be/lane helpers.
//   Sub-module load_align (combinational): rdata, addr[1:0], size, unsigned -> 32-bit wb value.
//   Top holds FSM, timeout counter, input capture registers, output registers.
// TESTING
//   Non-mem op ALUres=0x1234_5678 -> o_wb_valid next cycle, o_wb_data=0x1234_5678, o_stall never 1.
//   lb addr 0x0000_0103, rdata 0x80FF_0011, ack after 3 cycles -> be 4'b1000, wb_data 0xFFFF_FF80;
//     repeat with i_unsigned=1 -> 0x0000_0080; o_stall high accept..ack cycle.
//   sh addr 0x0000_0042, op2 0xAAAA_BEEF -> o_mem_be 4'b1100, o_mem_wdata 0xBEEF_BEEF, we=1,
//     o_mem_addr 0x0000_0040.
//   lw addr 0x0000_0006 -> no o_mem_req, o_misalign pulse, no o_wb_valid.
//   TIMEOUT=4, lw with no ack -> req held 4 cycles, o_bus_err pulse, FSM IDLE, stall released.
//   Assert i_rst in BUSY -> o_mem_req=0 immediately; after release no pulses, next lw completes.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants, FSM state encoding and byte-lane helpers for the memory-access stage.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } mem_state_t;

    // Size code 2'b11 falls into the word case everywhere below.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            default:   bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            SIZE_BYTE: lanes = {4{data[7:0]}};
            SIZE_HALF: lanes = {2{data[15:0]}};
            default:   lanes = data;
        endcase
        return lanes;
    endfunction

    function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] addr_lo);
        logic [7:0] lane;
        case (addr_lo)
            2'd0:    lane = word[7:0];
            2'd1:    lane = word[15:8];
            2'd2:    lane = word[23:16];
            default: lane = word[31:24];
        endcase
        return lane;
    endfunction

    function automatic logic [15:0] select_half(input logic [31:0] word, input logic upper);
        return upper ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed lane out of a little-endian read word and sign/zero extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] value
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = select_byte(rdata, addr_lo);
        half_lane = select_half(rdata, addr_lo[1]);
        case (size)
            SIZE_BYTE: value = is_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            SIZE_HALF: value = is_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default:   value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: one bus transaction per load/store, aligned load writeback, ALU pass-through.
// Holds the front end via o_stall while a transaction is outstanding.
module mem_access
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_ALUres,
    input  logic [31:0] i_op2,
    output logic        o_stall,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_wb_valid,
    output logic [31:0] o_wb_data,
    output logic        o_misalign,
    output logic        o_bus_err
);

    // Timer counts completed BUSY cycles; it only ever needs to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    mem_state_t    state;
    logic [TW-1:0] timer;
    logic [1:0]    addr_lo_q;
    logic [1:0]    size_q;
    logic          unsigned_q;
    logic          load_q;

    logic          mem_op;
    logic          misaligned;
    logic          idle_take;
    logic          accept_alu;
    logic          accept_mem;
    logic          reject;
    logic          timed_out;
    logic [31:0]   load_value;

    always_comb begin
        mem_op     = i_memRead | i_memWrite;
        misaligned = is_misaligned(i_size, i_ALUres[1:0]);
        idle_take  = (state == ST_IDLE) && i_valid;
        accept_alu = idle_take && !mem_op;
        reject     = idle_take && mem_op && misaligned;
        accept_mem = idle_take && mem_op && !misaligned;
        timed_out  = (TIMEOUT != 0) && (timer == TIMER_LAST);
        o_stall    = accept_mem || (state == ST_BUSY);
    end

    load_align u_load_align (
        .rdata       (i_mem_rdata),
        .addr_lo     (addr_lo_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .value       (load_value)
    );

    // Ack is tested before the timeout so a response on the last allowed cycle still completes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            addr_lo_q   <= 2'b00;
            size_q      <= SIZE_BYTE;
            unsigned_q  <= 1'b0;
            load_q      <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 32'h0;
            o_mem_be    <= 4'h0;
            o_mem_wdata <= 32'h0;
            o_wb_valid  <= 1'b0;
            o_wb_data   <= 32'h0;
            o_misalign  <= 1'b0;
            o_bus_err   <= 1'b0;
        end else begin
            o_wb_valid <= 1'b0;
            o_misalign <= 1'b0;
            o_bus_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_alu) begin
                        o_wb_data  <= i_ALUres;
                        o_wb_valid <= 1'b1;
                    end else if (reject) begin
                        o_misalign <= 1'b1;
                    end else if (accept_mem) begin
                        addr_lo_q   <= i_ALUres[1:0];
                        size_q      <= i_size;
                        unsigned_q  <= i_unsigned;
                        load_q      <= i_memRead;
                        timer       <= '0;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= i_memWrite;
                        o_mem_addr  <= {i_ALUres[31:2], 2'b00};
                        o_mem_be    <= byte_enables(i_size, i_ALUres[1:0]);
                        o_mem_wdata <= store_lanes(i_size, i_op2);
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (i_mem_ack) begin
                        o_mem_req  <= 1'b0;
                        o_mem_we   <= 1'b0;
                        o_wb_data  <= load_q ? load_value : 32'h0;
                        o_wb_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else if (timed_out) begin
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        o_bus_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
